// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed request-to-completion latency.
// One request in flight at a time; completion is a registered one-cycle ready pulse.
module dmem_responder #(
    parameter int n     = 32,
    parameter int DEPTH = 64,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         we,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] wdata,
    output logic         ready,
    output logic [n-1:0] rdata,
    output logic         err,
    output logic         busy
);

    localparam int CW = $clog2(LAT) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [n-3:0] DEPTH_W = (n-2)'(DEPTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [n-1:0]  a_q;
    logic          we_q;
    logic [n-1:0]  wd_q;
    logic          ready_q;
    logic          busy_q;
    logic          err_q;
    logic [n-1:0]  rdata_q;

    logic [n-1:0]  mem [DEPTH];

    logic [n-3:0]  word_idx;
    logic [AW-1:0] mem_idx;
    logic          fault;
    logic          access_done;
    logic [n-1:0]  rdata_d;

    assign word_idx    = a_q[n-1:2];
    assign mem_idx     = word_idx[AW-1:0];
    assign fault       = (a_q[1:0] != 2'b00) || (word_idx >= DEPTH_W);
    assign access_done = (state_q == S_WAIT) && (cnt_q == '0);

    // NOTE: every variable assigned in always_comb gets a value on every path
    // (default first), otherwise synthesis infers a latch.
    always_comb begin
        rdata_d = '0;
        if (!fault) begin
            rdata_d = we_q ? wd_q : mem[mem_idx];
        end
    end

    // NOTE: the storage array has no reset branch; resetting it would turn a
    // RAM into thousands of flops. An aborted access never reaches this edge
    // because reset forces the FSM out of WAIT.
    always_ff @(posedge clk) begin
        if (access_done && we_q && !fault) begin
            mem[mem_idx] <= wd_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        a_q     <= addr;
                        we_q    <= we;
                        wd_q    <= wdata;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q <= rdata_d;
                        err_q   <= fault;
                        ready_q <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_RESP: begin
                    // Requests seen here are dropped, not queued.
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vectors, corner sequences and
// randomized traffic checked against a transaction-level memory model.
module tb_dmem_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int DEPTH = 64;

    logic clk;
    logic reset;

    logic [1:0]  req_s;
    logic [1:0]  we_s;
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];

    logic        ready0, busy0, err0;
    logic [31:0] rdata0;
    logic        ready1, busy1, err1;
    logic [31:0] rdata1;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [2][DEPTH];

    dmem_responder #(.n(32), .DEPTH(DEPTH), .LAT(LAT0)) dut0 (
        .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]),
        .ready(ready0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    dmem_responder #(.n(32), .DEPTH(DEPTH), .LAT(LAT1)) dut1 (
        .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]),
        .ready(ready1), .rdata(rdata1), .err(err1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_ready(input int s);
        return (s == 0) ? ready0 : ready1;
    endfunction
    function automatic logic get_busy(input int s);
        return (s == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_err(input int s);
        return (s == 0) ? err0 : err1;
    endfunction
    function automatic logic [31:0] get_rdata(input int s);
        return (s == 0) ? rdata0 : rdata1;
    endfunction

    // Transaction-level model: result of one access, applied to the model memory.
    function automatic void model(input int s, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, output logic e, output logic [31:0] rd);
        int unsigned idx;
        idx = a >> 2;
        if (a[1:0] != 2'b00 || idx >= DEPTH) begin
            e  = 1'b1;
            rd = 32'h0;
        end else if (w) begin
            mem_m[s][idx] = d;
            e  = 1'b0;
            rd = d;
        end else begin
            e  = 1'b0;
            rd = mem_m[s][idx];
        end
    endfunction

    // Issues one request on an idle DUT and checks the cycle-by-cycle handshake.
    task automatic do_txn(input int s, input int lat, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic exp_e, input logic [31:0] exp_rd,
                          input string name);
        we_s[s]    = w;
        addr_s[s]  = a;
        wdata_s[s] = d;
        req_s[s]   = 1'b1;
        tick();
        check({name, " busy@accept"}, 32'(get_busy(s)), 32'd1);
        check({name, " ready@accept"}, 32'(get_ready(s)), 32'd0);
        for (int i = 1; i < lat; i++) begin
            tick();
            check({name, " ready@wait"}, 32'(get_ready(s)), 32'd0);
        end
        tick();
        check({name, " ready"}, 32'(get_ready(s)), 32'd1);
        check({name, " busy@resp"}, 32'(get_busy(s)), 32'd1);
        check({name, " err"}, 32'(get_err(s)), 32'(exp_e));
        check({name, " rdata"}, get_rdata(s), exp_rd);
        req_s[s]   = 1'b0;
        addr_s[s]  = $urandom;
        wdata_s[s] = $urandom;
        we_s[s]    = 1'($urandom);
        tick();
        check({name, " ready@idle"}, 32'(get_ready(s)), 32'd0);
        check({name, " busy@idle"}, 32'(get_busy(s)), 32'd0);
        check({name, " err@idle"}, 32'(get_err(s)), 32'd0);
        check({name, " rdata held"}, get_rdata(s), exp_rd);
    endtask

    task automatic model_txn(input int s, input int lat, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input string name);
        logic        e;
        logic [31:0] rd;
        model(s, w, a, d, e, rd);
        do_txn(s, lat, w, a, d, e, rd, name);
    endtask

    initial begin
        logic        e;
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        int          pick;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, "st_10"};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, "ld_10"};
        vecs[2]  = '{1'b0, 32'h13,  32'h0,        1'b1, 32'h0,        "ld_misalign"};
        vecs[3]  = '{1'b1, 32'h20,  32'h55AA55AA, 1'b0, 32'h55AA55AA, "st_20"};
        vecs[4]  = '{1'b1, 32'h22,  32'h00001234, 1'b1, 32'h0,        "st_misalign"};
        vecs[5]  = '{1'b0, 32'h20,  32'h0,        1'b0, 32'h55AA55AA, "ld_20"};
        vecs[6]  = '{1'b1, 32'hFC,  32'hA5A50063, 1'b0, 32'hA5A50063, "st_top"};
        vecs[7]  = '{1'b0, 32'hFC,  32'h0,        1'b0, 32'hA5A50063, "ld_top"};
        vecs[8]  = '{1'b1, 32'h0,   32'h11110000, 1'b0, 32'h11110000, "st_0"};
        vecs[9]  = '{1'b1, 32'h100, 32'h00009999, 1'b1, 32'h0,        "st_oor"};
        vecs[10] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h11110000, "ld_0"};
        vecs[11] = '{1'b0, 32'h100, 32'h0,        1'b1, 32'h0,        "ld_oor"};
        vecs[12] = '{1'b0, 32'hFFFFFFFC, 32'h0,   1'b1, 32'h0,        "ld_nowrap"};
        vecs[13] = '{1'b0, 32'h04,  32'h0,        1'b0, 32'h0,        "ld_4"};

        req_s      = '0;
        we_s       = '0;
        addr_s[0]  = '0;
        addr_s[1]  = '0;
        wdata_s[0] = '0;
        wdata_s[1] = '0;
        reset      = 1'b1;
        #2 reset   = 1'b0;
        #1;
        check("rst ready", 32'(ready0), 32'd0);
        check("rst busy", 32'(busy0), 32'd0);
        check("rst err", 32'(err0), 32'd0);
        check("rst rdata", rdata0, 32'h0);
        check("rst ready1", 32'(ready1), 32'd0);
        repeat (2) tick();
        reset = 1'b1;

        // Define every word so later loads never observe uninitialised storage.
        for (int i = 0; i < DEPTH; i++) begin
            model_txn(0, LAT0, 1'b1, 32'(i * 4), $urandom, "fill");
        end
        vecs[13].exp_rd = mem_m[0][1];

        for (int i = 0; i < 14; i++) begin
            model(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, e, rd);
            do_txn(0, LAT0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_err, vecs[i].exp_rd, vecs[i].name);
        end

        // Reset during WAIT aborts the store and suppresses the ready pulse.
        we_s[0]    = 1'b1;
        addr_s[0]  = 32'h8;
        wdata_s[0] = 32'hCAFEF00D;
        req_s[0]   = 1'b1;
        tick();
        check("abort busy@accept", 32'(busy0), 32'd1);
        #2 reset   = 1'b0;
        req_s[0]   = 1'b0;
        #1;
        check("abort busy", 32'(busy0), 32'd0);
        check("abort ready", 32'(ready0), 32'd0);
        check("abort rdata", rdata0, 32'h0);
        #1 reset   = 1'b1;
        for (int i = 0; i < LAT0 + 2; i++) begin
            tick();
            check("abort no ready", 32'(ready0), 32'd0);
            check("abort no busy", 32'(busy0), 32'd0);
        end
        model_txn(0, LAT0, 1'b0, 32'h8, 32'h0, "ld_after_abort");

        // Held req: dropped during RESP, restarted on the first IDLE edge.
        we_s[0]   = 1'b0;
        addr_s[0] = 32'h10;
        req_s[0]  = 1'b1;
        tick();
        for (int i = 1; i < LAT0; i++) tick();
        tick();
        check("held ready1", 32'(ready0), 32'd1);
        check("held rdata1", rdata0, mem_m[0][4]);
        tick();
        check("held no ready in idle", 32'(ready0), 32'd0);
        check("held busy idle", 32'(busy0), 32'd0);
        tick();
        check("held busy restart", 32'(busy0), 32'd1);
        check("held ready restart", 32'(ready0), 32'd0);
        for (int i = 1; i < LAT0; i++) begin
            tick();
            check("held ready wait", 32'(ready0), 32'd0);
        end
        tick();
        check("held ready2 spacing", 32'(ready0), 32'd1);
        req_s[0] = 1'b0;
        tick();
        check("held ready off", 32'(ready0), 32'd0);

        // LAT=1 instance.
        model_txn(1, LAT1, 1'b1, 32'h40, 32'h0BADF00D, "l1 st_40");
        model_txn(1, LAT1, 1'b0, 32'h40, 32'h0, "l1 ld_40");
        model_txn(1, LAT1, 1'b0, 32'h41, 32'h0, "l1 ld_misalign");
        model_txn(1, LAT1, 1'b1, 32'hFC, 32'h76543210, "l1 st_top");
        model_txn(1, LAT1, 1'b1, 32'h100, 32'h1, "l1 st_oor");
        model_txn(1, LAT1, 1'b0, 32'hFC, 32'h0, "l1 ld_top");

        // Randomized traffic on the LAT=2 instance.
        for (int i = 0; i < 200; i++) begin
            pick = $urandom_range(0, 9);
            w    = 1'($urandom);
            d    = $urandom;
            if (pick < 6)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (pick == 6) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (pick == 7) a = 32'($urandom_range(DEPTH, 4000) * 4);
            else if (pick == 8) a = 32'((DEPTH - 1) * 4);
            else                a = 32'(DEPTH * 4);
            model_txn(0, LAT0, w, a, d, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
